// File: rtl/eth_tx_pkg.sv
// Shared constants, state encodings and CRC helper for the Ethernet transmit path.
// The CRC items are only referenced when ETH_TX_CRC_EN is defined.
package eth_tx_pkg;

    localparam logic [15:0] ADDR_CR     = 16'hFC00;
    localparam logic [15:0] ADDR_LEN_LO = 16'hFC02;
    localparam logic [15:0] ADDR_LEN_HI = 16'hFC03;
    localparam logic [4:0]  BUF_TAG     = 5'b11101;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LEAD,
        SER_SHIFT,
        SER_TRAIL
    } ser_state_e;

    typedef enum logic [1:0] {
        SYS_IDLE,
        SYS_SEND,
        SYS_GAP
    } sys_state_e;

    // Reflected CRC-32 update, one byte consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_serializer.sv
// Byte-in/bit-out SPI mode-0 master: LEAD/SHIFT/TRAIL sequencing with an sck divider.
// Bytes after the first are pulled through a one-deep req/ack holding register.
module eth_tx_serializer
    import eth_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       byte_ack,
    input  logic [7:0] byte_data,
    output logic       byte_req,
    output logic       frame_done,
    output logic       tx_sck,
    output logic       tx_mosi,
    output logic       n_tx_ss
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    ser_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sr_q, sr_d;
    logic [7:0]       nxt_q, nxt_d;
    logic             nxt_vld_q, nxt_vld_d;
    logic             end_q, end_d;
    logic             div_done;

    assign div_done = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= SER_IDLE;
            div_q     <= '0;
            sck_q     <= 1'b0;
            bit_q     <= '0;
            sr_q      <= '0;
            nxt_q     <= '0;
            nxt_vld_q <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            nxt_q     <= nxt_d;
            nxt_vld_q <= nxt_vld_d;
            end_q     <= end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        sck_d     = sck_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        nxt_d     = nxt_q;
        nxt_vld_d = nxt_vld_q;
        end_d     = end_q;
        if (byte_ack) begin
            nxt_d     = byte_data;
            nxt_vld_d = 1'b1;
        end
        unique case (state_q)
            SER_IDLE: begin
                if (start) begin
                    state_d   = SER_LEAD;
                    div_d     = '0;
                    sck_d     = 1'b0;
                    bit_d     = '0;
                    sr_d      = byte_data;
                    nxt_vld_d = 1'b0;
                    end_d     = 1'b0;
                end
            end
            SER_LEAD: begin
                div_d = div_q + 1'b1;
                if (div_done) begin
                    state_d = SER_SHIFT;
                    div_d   = '0;
                    sck_d   = 1'b1;
                end
            end
            SER_SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_done) begin
                    div_d = '0;
                    if (sck_q) begin
                        // Falling edge: present the next bit, or the next byte after bit 7.
                        sck_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
                            if (nxt_vld_q) begin
                                sr_d      = nxt_q;
                                nxt_vld_d = 1'b0;
                            end else begin
                                sr_d  = {sr_q[6:0], 1'b0};
                                end_d = 1'b1;
                            end
                        end else begin
                            sr_d  = {sr_q[6:0], 1'b0};
                            bit_d = bit_q + 3'd1;
                        end
                    end else if (end_q) begin
                        state_d = SER_TRAIL;
                        end_d   = 1'b0;
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end
            SER_TRAIL: begin
                div_d = div_q + 1'b1;
                if (div_done) begin
                    state_d = SER_IDLE;
                    div_d   = '0;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        n_tx_ss    = (state_q == SER_IDLE);
        tx_sck     = (state_q == SER_SHIFT) && sck_q;
        tx_mosi    = (state_q != SER_IDLE) && sr_q[7];
        byte_req   = ((state_q == SER_LEAD) || (state_q == SER_SHIFT)) && !nxt_vld_q && !end_q;
        frame_done = (state_q == SER_TRAIL) && div_done;
    end

endmodule

// File: rtl/eth_transmitter_system.sv
// Memory-mapped transmit path: bus decode, 2 KiB frame buffer, LEN/CR registers and inter-frame gap.
// Build macro ETH_TX_CRC_EN appends a CRC-32 FCS (LSB byte first) after the LEN payload bytes.
module eth_transmitter_system
    import eth_tx_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 96
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] a,
    inout  wire  [7:0]  d,
    input  logic        n_we,
    input  logic        n_oe,
    output logic        n_rdy,
    output logic        tx_sck,
    output logic        tx_mosi,
    output logic        n_tx_ss
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [7:0]       frame_buf_q [0:2047];
    sys_state_e       sys_q, sys_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [11:0]      idx_q, idx_d;
    logic [10:0]      len_q, len_d;
    logic             done_q, done_d;
    logic             busy;
    logic             sel_buf, sel_cr, sel_lo, sel_hi, wr_en, start_req;
    logic [11:0]      total;
    logic [7:0]       feed_byte, rd_data;
    logic             ser_start, ser_ack, ser_req, ser_done;

    assign sel_buf   = (a[15:11] == BUF_TAG);
    assign sel_cr    = (a == ADDR_CR);
    assign sel_lo    = (a == ADDR_LEN_LO);
    assign sel_hi    = (a == ADDR_LEN_HI);
    assign wr_en     = !n_we;
    assign start_req = wr_en && sel_cr && d[0] && !busy && (len_q != 11'd0);
    assign n_rdy     = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en && sel_buf && !busy) begin
            frame_buf_q[a[10:0]] <= d;
        end
    end

`ifdef ETH_TX_CRC_EN
    logic [31:0] crc_q, crc_d, fcs;
    logic [1:0]  fcs_sel;

    assign total = {1'b0, len_q} + 12'd4;

    always_comb begin
        fcs       = crc_q ^ CRC_XOROUT;
        fcs_sel   = idx_q[1:0] - len_q[1:0];
        feed_byte = fcs[8*fcs_sel +: 8];
        if (idx_q < {1'b0, len_q}) begin
            feed_byte = frame_buf_q[idx_q[10:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign total     = {1'b0, len_q};
    assign feed_byte = frame_buf_q[idx_q[10:0]];
`endif

    always_ff @(posedge clk) begin
        if (n_rst) begin
            sys_q  <= SYS_IDLE;
            gap_q  <= '0;
            idx_q  <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sys_q  <= sys_d;
            gap_q  <= gap_d;
            idx_q  <= idx_d;
            len_q  <= len_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        sys_d     = sys_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        len_d     = len_q;
        done_d    = done_q;
        ser_start = 1'b0;
        ser_ack   = 1'b0;
`ifdef ETH_TX_CRC_EN
        crc_d     = crc_q;
`endif
        if (wr_en && sel_cr && d[1]) done_d = 1'b0;
        if (wr_en && sel_lo && !busy) len_d[7:0] = d;
        if (wr_en && sel_hi && !busy) len_d[10:8] = d[2:0];
        unique case (sys_q)
            SYS_IDLE: begin
                // Byte 0 goes straight into the shifter so mosi is valid as ss falls.
                if (start_req) begin
                    sys_d     = SYS_SEND;
                    ser_start = 1'b1;
                    idx_d     = 12'd1;
`ifdef ETH_TX_CRC_EN
                    crc_d     = crc32_byte(CRC_INIT, feed_byte);
`endif
                end
            end
            SYS_SEND: begin
                if (ser_req && (idx_q < total)) begin
                    ser_ack = 1'b1;
                    idx_d   = idx_q + 12'd1;
`ifdef ETH_TX_CRC_EN
                    if (idx_q < {1'b0, len_q}) crc_d = crc32_byte(crc_q, feed_byte);
`endif
                end
                if (ser_done) begin
                    sys_d = SYS_GAP;
                    gap_d = '0;
                    idx_d = '0;
                end
            end
            SYS_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    sys_d  = SYS_IDLE;
                    done_d = 1'b1;
                end
            end
            default: sys_d = SYS_IDLE;
        endcase
    end

    always_comb begin
        busy    = (sys_q != SYS_IDLE);
        rd_data = 8'h00;
        if (sel_buf)     rd_data = frame_buf_q[a[10:0]];
        else if (sel_cr) rd_data = {6'b0, done_q, busy};
        else if (sel_lo) rd_data = len_q[7:0];
        else if (sel_hi) rd_data = {5'b0, len_q[10:8]};
    end

    assign d = (!n_oe && (sel_buf || sel_cr || sel_lo || sel_hi)) ? rd_data : 8'hzz;

    eth_tx_serializer #(
        .CLK_DIV(CLK_DIV)
    ) u_serializer (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (ser_start),
        .byte_ack   (ser_ack),
        .byte_data  (feed_byte),
        .byte_req   (ser_req),
        .frame_done (ser_done),
        .tx_sck     (tx_sck),
        .tx_mosi    (tx_mosi),
        .n_tx_ss    (n_tx_ss)
    );

endmodule

// File: doc/eth_transmitter_system.md
# eth_transmitter_system

Memory-mapped Ethernet transmit path: the CPU fills an on-chip 2 KiB frame buffer over the system bus, programs a length, and sets a start bit. The block then clocks the frame out MSB-first as an SPI-style master (tx_sck, tx_mosi, n_tx_ss) toward the PHY/MAC controller. It is the outbound counterpart of the receive system and occupies its own address windows on the same CPU bus.

## Interface
- CLK_DIV, 2: tx_sck half-period in clk cycles (≥1).
- GAP_CYCLES, 96: minimum n_tx_ss-high cycles between frames.
- clk  input  1  system clock; bus and serializer are synchronous to it.
- n_rst  input  1  synchronous, active-high reset.
- a  input  16  CPU address.
- d  inout  8  CPU data; driven only on a selected read.
- n_we  input  1  active-low write strobe.
- n_oe  input  1  active-low read strobe.
- n_rdy  output  1  wait request; constant 0.
- tx_sck  output  1  serial clock, idle low.
- tx_mosi  output  1  serial data.
- n_tx_ss  output  1  frame select, active low.

## Operation
- Address map: buffer 0xE800–0xEFFF (a[15:11]=5'b11101, offset a[10:0]); CR 0xFC00; LEN_LO 0xFC02; LEN_HI 0xFC03 (bits [2:0] only).
- Buffer write: every clk with n_we=0 and buffer selected stores d at offset; ignored while busy. Reads return the stored byte (async read).
- LEN (11 bit): written via LEN_LO/LEN_HI; writes ignored while busy. Reads return the value, upper LEN_HI bits 0.
- CR read: {6'b0, done, busy}. CR write: d[1]=1 clears done; d[0]=1 starts if busy=0 and LEN≠0; start with LEN=0 is a no-op. Start and done-clear in the same write: done cleared, then frame starts.
- FSM: IDLE → LEAD (CLK_DIV cycles, n_tx_ss=0, mosi=bit7 of byte 0) → SHIFT (16·CLK_DIV cycles per byte, byte index 0..LEN-1) → TRAIL (CLK_DIV cycles, sck low, ss low) → GAP (GAP_CYCLES, ss high) → IDLE.
- SPI mode 0: mosi changes on sck falling edge (or at LEAD start for first bit), stable across rising edge.
- busy=1 from start through GAP; done set on GAP→IDLE transition, sticky.
- Outputs after reset: tx_sck=0, tx_mosi=0, n_tx_ss=1, busy=0, done=0, LEN=0, d high-Z. Buffer contents not cleared.
- Reset mid-frame: next cycle n_tx_ss=1, sck=0, FSM IDLE, no done.

## Timing
- Start write sampled at cycle S; n_tx_ss falls at S+1.
- First sck rising edge at S+1+CLK_DIV; one rising edge per bit, 8·LEN total (plus 32 with CRC).
- n_tx_ss low for (2+16·N)·CLK_DIV cycles, N = bytes sent; busy falls GAP_CYCLES later together with done rising.
- Bus reads: d valid combinationally while n_oe=0 and a selected.
- Byte index wraps never: LEN ≤ 2047 bounds offset.

## Configuration
- ETH_TX_CRC_EN defined: CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) computed over the LEN bytes; 4 FCS bytes appended least-significant byte first, N=LEN+4.
- Undefined: exactly LEN bytes sent, no CRC logic.

## Structure
- Package eth_tx_pkg: address constants, FSM state enum, CRC polynomial/init constants.
- Sub-module eth_tx_serializer: byte-in/bit-out shift register with sck divider, LEAD/SHIFT/TRAIL sequencing, byte-request handshake (req/ack per byte); the top holds bus decode, buffer, LEN/CR and GAP timing.

## Test plan
- Reset: assert n_rst one cycle → n_tx_ss=1, sck=0, CR reads 0x00, LEN reads 0x000.
- Write A5,01,FF to 0xE800–0xE802, LEN=3, CR=0x01 → 24 sck rising edges, mosi 10100101 00000001 11111111, CR reads 0x01 during frame, 0x02 after.
- LEN=0, CR=0x01 → no n_tx_ss activity, CR stays 0x00.
- During busy: write 0x00 to 0xE800, LEN_LO=5, CR=0x01 → frame unchanged, buffer still A5, LEN still 3; CR=0x02 after done → reads 0x00.
- Reset at bit 10 of frame → next cycle n_tx_ss=1; new start transmits full frame from byte 0.
- ETH_TX_CRC_EN: buffer "123456789" (0x31..0x39), LEN=9 → 13 bytes, last four 26 39 F4 CB.
